// File: rtl/riscv_wb_pkg.sv
// Shared writeback types: the register-file write beat and the arbitration source.
package riscv_wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for LSU results. Depth is a power of two; pointers carry
// one extra wrap bit so full and empty are distinguishable without a counter.
module wb_fifo
  import riscv_wb_pkg::*;
#(
  parameter int  Q_DEPTH = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int IDX_W = $clog2(Q_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  entry_t           r_mem [Q_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone decide
  // which entries are live, so resetting data would only cost reset routing.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[IDX_W-1:0]] <= push_data;
  end

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                 (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
  assign head  = r_mem[r_rd_ptr[IDX_W-1:0]];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/writeback_arbiter.sv
// Owns the register-file write port: arbitrates ALU results against buffered LSU
// results, registers the write beat and tracks long-latency destinations as busy.
module writeback_arbiter #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int Q_DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  wb_stall,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  issue_long,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  output logic                  dec_stall,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       write_data
);

  import riscv_wb_pkg::*;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } entry_t;

  localparam int                    NREGS    = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(REG_ZERO);
  localparam logic [NREGS-1:0]      X0_MASK  = {{(NREGS-1){1'b1}}, 1'b0};

  logic    w_full;
  logic    w_empty;
  logic    w_push;
  logic    w_pop;
  entry_t  w_head;
  entry_t  w_lsu_entry;
  entry_t  w_win;
  wb_src_e w_src;

  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_write_data;

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_set;
  logic [NREGS-1:0] w_busy_clr;

  assign lsu_ready   = !w_full && !rst;
  assign w_push      = lsu_valid && lsu_ready;
  assign w_lsu_entry = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(
    .Q_DEPTH (Q_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_lsu_entry),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  // A full FIFO drains first so the LSU is never blocked indefinitely by ALU traffic.
  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_src = SRC_NONE;
    if (w_full)        w_src = SRC_FIFO;
    else if (alu_valid) w_src = SRC_ALU;
    else if (!w_empty)  w_src = SRC_FIFO;
  end

  always_comb begin
    w_win = w_head;
    if (w_src == SRC_ALU) w_win = '{rd: alu_rd, data: alu_data};
  end

  assign w_pop    = (w_src == SRC_FIFO) && !rst;
  assign wb_stall = w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= (w_src != SRC_NONE) && (w_win.rd != ZERO_IDX);
      if (w_src != SRC_NONE) begin
        r_rd         <= w_win.rd;
        r_write_data <= w_win.data;
      end
    end
  end

  assign RegWrite   = r_reg_write;
  assign rd         = r_rd;
  assign write_data = r_write_data;

  // Clear follows the registered write so dec_stall drops exactly when the
  // register file can return the new value; a coincident set takes priority.
  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (r_reg_write)                          w_busy_clr[r_rd]     = 1'b1;
    if (issue_long && (issue_rd != ZERO_IDX)) w_busy_set[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & X0_MASK;
  end

  assign dec_stall = r_busy[rs1] | r_busy[rs2] | r_busy[dec_rd];

  a_issue_not_busy: assert property (@(posedge clk) disable iff (rst)
    (issue_long && (issue_rd != ZERO_IDX)) |-> !r_busy[issue_rd]);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based model of the writeback rules.
module tb_writeback_arbiter;

  localparam int QD = 2;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        wb_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  dec_rd;
  logic        dec_stall;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] write_data;

  writeback_arbiter #(.XLEN(32), .REG_ADDR_W(5), .Q_DEPTH(QD)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .wb_stall   (wb_stall),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .issue_long (issue_long),
    .issue_rd   (issue_rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .dec_rd     (dec_rd),
    .dec_stall  (dec_stall),
    .RegWrite   (RegWrite),
    .rd         (rd),
    .write_data (write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_long;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  dec_rd;
  } stim_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  stim_t nx;

  // Reference model state.
  ent_t        q[$];
  bit          busy[32];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_hold;

  int  checks;
  int  errors;
  bit  cmp_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic apply();
    rst        = nx.rst;
    alu_valid  = nx.alu_valid;
    alu_rd     = nx.alu_rd;
    alu_data   = nx.alu_data;
    lsu_valid  = nx.lsu_valid;
    lsu_rd     = nx.lsu_rd;
    lsu_data   = nx.lsu_data;
    issue_long = nx.issue_long;
    issue_rd   = nx.issue_rd;
    rs1        = nx.rs1;
    rs2        = nx.rs2;
    dec_rd     = nx.dec_rd;
  endtask

  // One cycle: drive staged inputs at negedge, compare against the model,
  // then advance the model to the state after the coming rising edge.
  task automatic step();
    bit   full;
    bit   empty;
    bit   win;
    ent_t w;
    @(negedge clk);
    apply();
    #1;
    full  = (q.size() == QD);
    empty = (q.size() == 0);
    if (cmp_en) begin
      check("lsu_ready",  {31'd0, lsu_ready}, {31'd0, (!full && !nx.rst)});
      check("wb_stall",   {31'd0, wb_stall},  {31'd0, full});
      check("dec_stall",  {31'd0, dec_stall},
            {31'd0, (busy[nx.rs1] | busy[nx.rs2] | busy[nx.dec_rd])});
      check("RegWrite",   {31'd0, RegWrite},  {31'd0, m_we});
      check("rd",         {27'd0, rd},        {27'd0, m_rd});
      check("write_data", write_data,         m_data);
    end
    if (nx.rst) begin
      q.delete();
      foreach (busy[i]) busy[i] = 1'b0;
      m_we   = 1'b0;
      m_rd   = '0;
      m_data = '0;
      m_hold = 1'b0;
    end else begin
      win = 1'b0;
      w   = '0;
      if (full) begin
        w = q.pop_front(); win = 1'b1;
      end else if (nx.alu_valid) begin
        w = '{rd: nx.alu_rd, data: nx.alu_data}; win = 1'b1;
      end else if (!empty) begin
        w = q.pop_front(); win = 1'b1;
      end
      if (nx.lsu_valid && !full) q.push_back('{rd: nx.lsu_rd, data: nx.lsu_data});
      if (m_we) busy[m_rd] = 1'b0;
      if (nx.issue_long && nx.issue_rd != 5'd0) busy[nx.issue_rd] = 1'b1;
      m_we = win && (w.rd != 5'd0);
      if (win) begin
        m_rd   = w.rd;
        m_data = w.data;
      end
      m_hold = full && nx.alu_valid;
    end
  endtask

  task automatic idle_step();
    nx = '0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    m_we = 1'b0; m_rd = '0; m_data = '0; m_hold = 1'b0;
    foreach (busy[i]) busy[i] = 1'b0;
    nx = '0;
    nx.rst = 1'b1;
    apply();

    // Reset held for two cycles, then released.
    step();
    cmp_en = 1'b1;
    step();
    nx = '0;
    step();
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_rd", {27'd0, rd}, 32'd0);
    check("rst_wdata", write_data, 32'd0);
    check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
    check("rst_dec_stall", {31'd0, dec_stall}, 32'd0);

    // ALU write lands one cycle later.
    nx = '0; nx.alu_valid = 1'b1; nx.alu_rd = 5'd5; nx.alu_data = 32'hDEAD_BEEF;
    step();
    idle_step();
    check("alu_we", {31'd0, RegWrite}, 32'd1);
    check("alu_rd", {27'd0, rd}, 32'd5);
    check("alu_data", write_data, 32'hDEAD_BEEF);

    // Scoreboard round trip on x7.
    nx = '0; nx.issue_long = 1'b1; nx.issue_rd = 5'd7; nx.dec_rd = 5'd7;
    step();
    nx = '0; nx.rs1 = 5'd7;
    step();
    check("sb_busy7", {31'd0, dec_stall}, 32'd1);
    nx = '0; nx.rs1 = 5'd7; nx.lsu_valid = 1'b1; nx.lsu_rd = 5'd7; nx.lsu_data = 32'h1234;
    step();
    nx = '0; nx.rs1 = 5'd7;
    step();
    check("sb_nowrite_yet", {31'd0, RegWrite}, 32'd0);
    step();
    check("sb_lsu_we", {31'd0, RegWrite}, 32'd1);
    check("sb_lsu_rd", {27'd0, rd}, 32'd7);
    check("sb_lsu_data", write_data, 32'h1234);
    check("sb_still_busy", {31'd0, dec_stall}, 32'd1);
    step();
    check("sb_cleared", {31'd0, dec_stall}, 32'd0);

    // FIFO-full priority with the ALU always valid.
    nx = '0; nx.alu_valid = 1'b1; nx.alu_rd = 5'd2; nx.alu_data = 32'h21;
    nx.lsu_valid = 1'b1; nx.lsu_rd = 5'd10; nx.lsu_data = 32'hA;
    step();
    nx.alu_data = 32'h22; nx.lsu_rd = 5'd11; nx.lsu_data = 32'hB;
    step();
    nx.alu_rd = 5'd3; nx.alu_data = 32'h33; nx.lsu_rd = 5'd12; nx.lsu_data = 32'hC;
    step();
    check("full_wb_stall", {31'd0, wb_stall}, 32'd1);
    check("full_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    check("full_prev_alu", write_data, 32'h22);
    nx.lsu_valid = 1'b0;
    step();
    check("drain_wb_stall", {31'd0, wb_stall}, 32'd0);
    check("drain_head_rd", {27'd0, rd}, 32'd10);
    check("drain_head_data", write_data, 32'hA);
    idle_step();
    check("held_alu_rd", {27'd0, rd}, 32'd3);
    check("held_alu_data", write_data, 32'h33);
    idle_step();
    check("drain_second_rd", {27'd0, rd}, 32'd11);
    check("drain_second_data", write_data, 32'hB);
    idle_step();
    check("rejected_push", {31'd0, RegWrite}, 32'd0);

    // Writes to x0 are consumed but never commit; busy[0] never sets.
    nx = '0; nx.alu_valid = 1'b1; nx.alu_rd = 5'd0; nx.alu_data = 32'hFFFF_FFFF;
    step();
    idle_step();
    check("x0_alu_we", {31'd0, RegWrite}, 32'd0);
    nx = '0; nx.lsu_valid = 1'b1; nx.lsu_rd = 5'd0; nx.lsu_data = 32'h5;
    step();
    idle_step();
    idle_step();
    check("x0_lsu_we", {31'd0, RegWrite}, 32'd0);
    check("x0_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    nx = '0; nx.issue_long = 1'b1; nx.issue_rd = 5'd0;
    step();
    idle_step();
    check("x0_never_busy", {31'd0, dec_stall}, 32'd0);

    // Reset mid-operation with two buffered results and x9 busy.
    nx = '0; nx.issue_long = 1'b1; nx.issue_rd = 5'd9; nx.dec_rd = 5'd9;
    step();
    nx = '0; nx.rs1 = 5'd9; nx.alu_valid = 1'b1; nx.alu_rd = 5'd1; nx.alu_data = 32'h11;
    nx.lsu_valid = 1'b1; nx.lsu_rd = 5'd20; nx.lsu_data = 32'h20;
    step();
    check("mid_busy9", {31'd0, dec_stall}, 32'd1);
    nx.alu_data = 32'h12; nx.lsu_rd = 5'd21; nx.lsu_data = 32'h21;
    step();
    nx = '0; nx.rst = 1'b1; nx.rs1 = 5'd9;
    step();
    check("mid_rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    nx = '0; nx.rs1 = 5'd9;
    step();
    check("post_rst_we", {31'd0, RegWrite}, 32'd0);
    check("post_rst_dec_stall", {31'd0, dec_stall}, 32'd0);
    check("post_rst_wb_stall", {31'd0, wb_stall}, 32'd0);
    idle_step();
    check("post_rst_fifo_empty", {31'd0, RegWrite}, 32'd0);

    // Random traffic obeying the decode/ALU protocol.
    for (int c = 0; c < 4000; c++) begin
      stim_t s;
      s = '0;
      if (m_hold) begin
        s.alu_valid = 1'b1;
        s.alu_rd    = nx.alu_rd;
        s.alu_data  = nx.alu_data;
      end else begin
        s.alu_valid = ($urandom_range(0, 99) < 45);
        s.alu_rd    = 5'($urandom_range(0, 15));
        s.alu_data  = $urandom;
      end
      s.lsu_valid = ($urandom_range(0, 99) < 40);
      s.lsu_rd    = 5'($urandom_range(0, 15));
      s.lsu_data  = $urandom;
      s.rs1       = 5'($urandom_range(0, 15));
      s.rs2       = 5'($urandom_range(0, 15));
      s.dec_rd    = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 25) begin
        s.issue_rd = 5'($urandom_range(0, 15));
        s.dec_rd   = s.issue_rd;
        if (!busy[s.rs1] && !busy[s.rs2] && !busy[s.dec_rd]) s.issue_long = 1'b1;
      end
      s.rst = ($urandom_range(0, 299) == 0);
      nx = s;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
